pipe_flush_ctrl: RTL and testbench
==================================

PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, legal 1..7; the number of drain cycles after the trigger cycle.
REQ-002 SHALL have ports:
- clk  input  1  clock, rising-edge.
- resetn  input  1  reset, asynchronous, active-low.
- ws_ex  input  1  WB exception commit, already qualified by WB valid.
- ertn_flush  input  1  WB ertn commit, already qualified by WB valid.
- ws_ecode  input  6  WB exception code.
- ws_pc  input  32  WB PC.
- csr_eentry  input  32  exception entry address.
- csr_era  input  32  ertn return address.
- redirect_ready  input  1  IF accepts the redirect.
- pipe_flush  output  1  kill all valid bits in IF/ID/EX/MEM/WB.
- redirect_valid  output  1  redirect request to IF.
- redirect_pc  output  32  redirect target.
- busy  output  1  controller not in IDLE.
- ex_count  output  16  committed exception count, saturating.
- last_ecode  output  6  ecode of last accepted exception.

Function
REQ-003 SHALL implement FSM states IDLE, DRAIN, REDIR.
REQ-004 Trigger = (ws_ex | ertn_flush) while state is IDLE.
REQ-005 In IDLE, pipe_flush SHALL equal trigger combinationally, so every stage clears at the trigger-cycle edge.
REQ-006 On trigger, the target SHALL be latched at the same edge:
- csr_eentry if ws_ex = 1;
- else csr_era.
REQ-007 If ws_ex and ertn_flush are both 1, ws_ex SHALL win: target is csr_eentry and it counts as an exception.
REQ-008 On trigger, the FSM SHALL go to DRAIN and load drain counter = FLUSH_CYCLES-1 (3-bit).
REQ-009 In DRAIN, pipe_flush SHALL be 1 and the counter SHALL decrement each cycle; at counter = 0 the FSM SHALL go to REDIR at the next edge.
REQ-010 Result: pipe_flush is high for exactly FLUSH_CYCLES+1 consecutive cycles (trigger cycle plus drain).
REQ-011 In REDIR:
- pipe_flush = 0;
- redirect_valid = 1;
- redirect_pc = latched target, held stable until handshake.
REQ-012 Handshake = redirect_valid & redirect_ready; on handshake the FSM SHALL return to IDLE and redirect_valid SHALL deassert the next cycle.
REQ-013 redirect_ready low SHALL hold REDIR indefinitely with no timeout.
REQ-014 ws_ex or ertn_flush asserted in DRAIN or REDIR SHALL be ignored: no re-latch, no count.
REQ-015 busy = (state != IDLE), registered-state decode.
REQ-016 On a trigger with ws_ex = 1:
- ex_count SHALL increment by 1 and saturate at 16'hFFFF;
- last_ecode SHALL latch ws_ecode.
REQ-017 ertn SHALL NOT change ex_count or last_ecode.
REQ-018 redirect_pc SHALL be 0 whenever redirect_valid = 0.
REQ-019 A trigger is accepted again in the same cycle the FSM returns to IDLE, i.e. the cycle after the handshake.

Reset
REQ-020 resetn low SHALL asynchronously force:
- state IDLE, drain counter 0, target 0;
- ex_count 0, last_ecode 0;
- pipe_flush 0, redirect_valid 0, redirect_pc 0, busy 0.
REQ-021 Reset asserted mid-DRAIN or mid-REDIR SHALL abort the sequence; no redirect is issued after release.
REQ-022 The first trigger SHALL be accepted at the first rising edge after resetn deasserts.

Structure
REQ-023 The FSM state encodings and the ecode constants (INT 6'h0, ADEF 6'h8, ALE 6'h9, SYS 6'hb, BRK 6'hc, INE 6'hd) SHALL live in the shared CPU package/header.
REQ-024 SHALL be a single module with no sub-modules; the saturating counter stays inline.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ws_ex=1, csr_eentry=0x1C008000, FLUSH_CYCLES=2, redirect_ready=1 -> pipe_flush high cycles T..T+2; redirect_valid at T+3 with pc 0x1C008000; ex_count=1.
- ertn_flush=1, csr_era=0x1C000104 -> redirect_pc 0x1C000104; ex_count unchanged.
- ws_ex=1 and ertn_flush=1 in the same cycle, ws_ecode=6'hb -> target csr_eentry, last_ecode 0xb.
- redirect_ready held low 10 cycles -> redirect_valid and redirect_pc stable for all 10; second ws_ex pulse in that window is ignored.
- ex_count preloaded via 65535 triggers, then one more ws_ex -> ex_count stays 0xFFFF.
- resetn pulsed low during DRAIN -> all outputs 0 immediately; no redirect_valid afterwards.

Source files
------------

// File: rtl/pipe_flush_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_flush_ctrl_pkg
// Shared CPU definitions used by the pipeline flush controller: the flush FSM
// state encoding and the exception code (ecode) constants reported by WB.
// -----------------------------------------------------------------------------
package pipe_flush_ctrl_pkg;

  // Flush controller FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for an exception / ertn commit
    ST_DRAIN = 2'd1,  // holding pipe_flush while in-flight work drains
    ST_REDIR = 2'd2   // presenting the redirect target to IF
  } flush_state_e;

  // Exception codes as carried on ws_ecode.
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;

  // Width of the drain down-counter (FLUSH_CYCLES is limited to 1..7).
  localparam int unsigned DRAIN_CNT_W = 3;

endpackage : pipe_flush_ctrl_pkg

// File: rtl/pipe_flush_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_flush_ctrl
// Turns a WB exception or ertn commit into a pipeline flush followed by a
// redirect request to IF. The flush is asserted combinationally in the commit
// cycle, held for FLUSH_CYCLES further drain cycles, and then the latched
// target (exception entry or ertn return address) is offered to IF until it
// is accepted. Commits arriving while a sequence is in progress are ignored.
//
// Parameters
//   FLUSH_CYCLES   drain cycles after the trigger cycle (1..7)
// Ports
//   clk            rising-edge clock
//   resetn         asynchronous active-low reset
//   ws_ex          WB exception commit (already qualified by WB valid)
//   ertn_flush     WB ertn commit (already qualified by WB valid)
//   ws_ecode       WB exception code
//   ws_pc          WB PC (informational, not used for the redirect)
//   csr_eentry     exception entry address
//   csr_era        ertn return address
//   redirect_ready IF accepts the redirect
//   pipe_flush     kill all valid bits in IF/ID/EX/MEM/WB
//   redirect_valid redirect request to IF
//   redirect_pc    redirect target, zero while redirect_valid is low
//   busy           controller not in IDLE
//   ex_count       committed exception count, saturating at 16'hFFFF
//   last_ecode     ecode of the last accepted exception
// -----------------------------------------------------------------------------
module pipe_flush_ctrl
  import pipe_flush_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_ex,
  input  logic        ertn_flush,
  input  logic [5:0]  ws_ecode,
  input  logic [31:0] ws_pc,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  input  logic        redirect_ready,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [15:0] ex_count,
  output logic [5:0]  last_ecode
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(FLUSH_CYCLES - 1);

  flush_state_e           state;
  flush_state_e           state_next;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [31:0]            target;
  logic                   trigger;
  logic                   ws_pc_unused;

  // The WB PC is part of the commit bundle but the redirect never needs it.
  assign ws_pc_unused = ^ws_pc;

  // Gating with resetn keeps the combinational flush low while reset is held,
  // so every output reads zero for the whole reset window.
  assign trigger = resetn && (state == ST_IDLE) && (ws_ex || ertn_flush);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      target     <= '0;
      ex_count   <= '0;
      last_ecode <= '0;
    end else begin
      state <= state_next;

      if (trigger) begin
        drain_cnt <= DRAIN_LOAD;
        // An exception beats a simultaneous ertn.
        target    <= ws_ex ? csr_eentry : csr_era;
      end else if (state == ST_DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      if (trigger && ws_ex) begin
        if (ex_count != 16'hFFFF) begin
          ex_count <= ex_count + 16'd1;
        end
        last_ecode <= ws_ecode;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;

    unique case (state)
      ST_IDLE: begin
        pipe_flush = trigger;
        if (trigger) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        pipe_flush = 1'b1;
        if (drain_cnt == '0) begin
          state_next = ST_REDIR;
        end
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        // No timeout: IF may stall the redirect for as long as it needs.
        if (redirect_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign redirect_pc = redirect_valid ? target : 32'h0;
  assign busy        = (state != ST_IDLE);

endmodule : pipe_flush_ctrl

// File: tb/tb_pipe_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_flush_ctrl
// Directed bench for pipe_flush_ctrl. Expected redirect targets are pushed to
// a queue when a commit is driven and popped when the DUT raises
// redirect_valid; the exception counter and last ecode follow a small model.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipe_flush_ctrl;
  import pipe_flush_ctrl_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_ex;
  logic        ertn_flush;
  logic [5:0]  ws_ecode;
  logic [31:0] ws_pc;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        redirect_ready;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [15:0] ex_count;
  logic [5:0]  last_ecode;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb[$];
  logic [15:0] exp_count = 16'h0;
  logic [5:0]  exp_ecode = 6'h0;

  pipe_flush_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ws_ex          (ws_ex),
    .ertn_flush     (ertn_flush),
    .ws_ecode       (ws_ecode),
    .ws_pc          (ws_pc),
    .csr_eentry     (csr_eentry),
    .csr_era        (csr_era),
    .redirect_ready (redirect_ready),
    .pipe_flush     (pipe_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .ex_count       (ex_count),
    .last_ecode     (last_ecode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rv"},    {31'h0, redirect_valid}, 32'h0);
    check({tag, "_pc0"},   redirect_pc,             32'h0);
    check({tag, "_busy"},  {31'h0, busy},           32'h0);
    check({tag, "_count"}, {16'h0, ex_count},       {16'h0, exp_count});
    check({tag, "_ecode"}, {26'h0, last_ecode},     {26'h0, exp_ecode});
  endtask

  // Drive one commit (now=1: in the current cycle) and check the flush window.
  task automatic fire(input string tag, input bit now, input logic ex,
                      input logic ertn, input logic [5:0] ecode, input logic [31:0] exp_pc);
    if (!now) @(negedge clk);
    ws_ex      = ex;
    ertn_flush = ertn;
    ws_ecode   = ecode;
    #1;
    check({tag, "_trig_flush"}, {31'h0, pipe_flush}, 32'h1);
    check({tag, "_trig_busy"},  {31'h0, busy},       32'h0);
    sb.push_back(exp_pc);
    if (ex) begin
      exp_count = (exp_count == 16'hFFFF) ? exp_count : exp_count + 16'd1;
      exp_ecode = ecode;
    end
    for (int i = 1; i <= FC; i++) begin
      @(negedge clk);
      ws_ex      = 1'b0;
      ertn_flush = 1'b0;
      #1;
      check({tag, "_drain_flush"}, {31'h0, pipe_flush},     32'h1);
      check({tag, "_drain_rv"},    {31'h0, redirect_valid}, 32'h0);
    end
    @(negedge clk);
    #1;
    check({tag, "_end_flush"}, {31'h0, pipe_flush}, 32'h0);
  endtask

  // Wait (bounded) for the redirect, compare it with the scoreboard, hold it
  // for 'hold' cycles with redirect_ready low, then complete the handshake.
  task automatic expect_redirect(input string tag, input int hold);
    logic [31:0] exp_pc;
    int          waited;
    waited = 0;
    while (redirect_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (redirect_valid !== 1'b1) begin
      n_checks++;
      $error("FAIL %s_timeout: observed no redirect_valid required redirect within 20 cycles", tag);
      return;
    end
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s_sb: observed redirect with empty queue required no redirect", tag);
      return;
    end
    exp_pc = sb.pop_front();
    check({tag, "_pc"}, redirect_pc, exp_pc);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      // One stray exception commit in the middle of the stall window.
      ws_ex = (i == hold / 2);
      if (ws_ex) begin
        ws_ecode   = ECODE_BRK;
        csr_eentry = 32'hDEAD_0000;
      end
      #1;
      check({tag, "_hold_rv"},    {31'h0, redirect_valid}, 32'h1);
      check({tag, "_hold_pc"},    redirect_pc,             exp_pc);
      check({tag, "_hold_flush"}, {31'h0, pipe_flush},     32'h0);
    end
    if (hold > 1) begin
      @(negedge clk);
      ws_ex          = 1'b0;
      redirect_ready = 1'b1;
      #1;
      check({tag, "_rel_rv"}, {31'h0, redirect_valid}, 32'h1);
    end
    @(negedge clk);
    #1;
    check_idle({tag, "_done"});
  endtask

  initial begin
    resetn         = 1'b0;
    ws_ex          = 1'b1;  // held during reset: must not flush
    ertn_flush     = 1'b0;
    ws_ecode       = ECODE_ALE;
    ws_pc          = 32'h1C00_0040;
    csr_eentry     = 32'h1C00_8000;
    csr_era        = 32'h1C00_0104;
    redirect_ready = 1'b1;

    @(negedge clk);
    #1;
    check("rst_flush", {31'h0, pipe_flush}, 32'h0);
    check_idle("rst");

    // Exception accepted at the first edge after reset release.
    @(negedge clk);
    resetn = 1'b1;
    fire("ex1", 1'b1, 1'b1, 1'b0, ECODE_ALE, 32'h1C00_8000);
    expect_redirect("ex1", 1);

    // ertn; then an exception in the very cycle IDLE is re-entered.
    fire("ertn", 1'b0, 1'b0, 1'b1, ECODE_INE, 32'h1C00_0104);
    expect_redirect("ertn", 1);
    fire("b2b", 1'b1, 1'b1, 1'b0, ECODE_ADEF, 32'h1C00_8000);
    expect_redirect("b2b", 1);

    // Simultaneous exception and ertn: exception wins.
    fire("both", 1'b0, 1'b1, 1'b1, ECODE_SYS, 32'h1C00_8000);
    expect_redirect("both", 1);

    // IF stalls the redirect for 10 cycles; a stray commit is ignored.
    csr_era        = 32'h1C00_0200;
    redirect_ready = 1'b0;
    fire("stall", 1'b0, 1'b0, 1'b1, ECODE_INT, 32'h1C00_0200);
    expect_redirect("stall", 10);

    // Saturation: preload one below the limit, then two more exceptions.
    csr_eentry = 32'h1C00_9000;
    @(negedge clk);
    force dut.ex_count = 16'hFFFE;
    #1;
    release dut.ex_count;
    exp_count = 16'hFFFE;
    fire("sat1", 1'b0, 1'b1, 1'b0, ECODE_INE, 32'h1C00_9000);
    expect_redirect("sat1", 1);
    fire("sat2", 1'b0, 1'b1, 1'b0, ECODE_BRK, 32'h1C00_9000);
    expect_redirect("sat2", 1);

    // Reset in the middle of DRAIN aborts the sequence.
    @(negedge clk);
    csr_eentry = 32'h1C00_F000;
    ws_ex      = 1'b1;
    ws_ecode   = ECODE_INT;
    @(negedge clk);
    ws_ex = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h1);
    #1;
    resetn = 1'b0;
    #1;
    exp_count = 16'h0;
    exp_ecode = 6'h0;
    check("abort_flush", {31'h0, pipe_flush}, 32'h0);
    check_idle("abort_rst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_rv",   {31'h0, redirect_valid}, 32'h0);
      check("abort_no_busy", {31'h0, busy},           32'h0);
    end

    // Controller works normally after the aborted sequence.
    fire("post", 1'b0, 1'b0, 1'b1, ECODE_INT, 32'h1C00_0200);
    expect_redirect("post", 1);
    check("sb_empty", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running required finish");
    $fatal(1, "bench time limit reached");
  end

endmodule : tb_pipe_flush_ctrl
